// File: rtl/ex_issue_if.sv
// Decode-to-issue interface of the ID/EX issue scheduler: decoded operand info in,
// latch controls and registered writeback announcement out.
interface ex_issue_if #(
    parameter int ADDR_W = 6,
    parameter int LAT_W  = 4
);
    logic              id_valid;
    logic [2:0]        id_func_select;
    logic [LAT_W-1:0]  id_latency;
    logic              id_has_dest;
    logic [ADDR_W-1:0] id_dest_addr;
    logic              id_src1_used;
    logic [ADDR_W-1:0] id_src1_addr;
    logic              id_src2_used;
    logic [ADDR_W-1:0] id_src2_addr;
    logic              ex_stall_in;
    logic              flush;
    logic              id_stall;
    logic              idex_stall;
    logic              idex_clr;
    logic              issue_fire;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_dest_addr;

    // Handshake: id_valid offers an instruction; it is taken at the edge where issue_fire=1,
    // otherwise decode must hold it (id_stall=1) unless flush kills it.
    modport master (
        output id_valid, id_func_select, id_latency, id_has_dest, id_dest_addr,
               id_src1_used, id_src1_addr, id_src2_used, id_src2_addr, ex_stall_in, flush,
        input  id_stall, idex_stall, idex_clr, issue_fire, wb_valid, wb_dest_addr
    );
    modport slave (
        input  id_valid, id_func_select, id_latency, id_has_dest, id_dest_addr,
               id_src1_used, id_src1_addr, id_src2_used, id_src2_addr, ex_stall_in, flush,
        output id_stall, idex_stall, idex_clr, issue_fire, wb_valid, wb_dest_addr
    );
endinterface

// File: rtl/ex_issue_scheduler.sv
// ID/EX issue scheduler: RAW/WAW, writeback-port and complex-ALU hazard checks for fixed-latency ops.
// Optional SCHED_PERF_CNT_EN adds saturating stall performance counters.
module ex_issue_scheduler #(
    parameter int         ADDR_W         = 6,
    parameter int         LAT_W          = 4,
    parameter logic [2:0] COMPLEX_FU_SEL = 3'd2
) (
    input logic clk,
    input logic reset,
    ex_issue_if.slave bus
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_raw_stalls
`endif
);
    localparam int NUM_REGS = 1 << ADDR_W;
    // slot[k] holds a writeback due k cycles from now; latency-1 ops go straight to wb_*.
    localparam int NSLOT    = (1 << LAT_W) - 2;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NSLOT:1]      slot_v_q, slot_v_d;
    logic [ADDR_W-1:0]   slot_dst_q [1:NSLOT];
    logic [ADDR_W-1:0]   slot_dst_d [1:NSLOT];
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_dest_q, wb_dest_d;
    logic [LAT_W-1:0]    busy_q, busy_d;

    logic [LAT_W-1:0] lat;
    logic raw1, raw2, raw, waw, wbcol, cbusy, hazard, fire;

    always_comb begin
        lat   = (bus.id_latency == '0) ? LAT_W'(1) : bus.id_latency;
        raw1  = bus.id_src1_used & pending_q[bus.id_src1_addr]
                & !(wb_valid_q && (wb_dest_q == bus.id_src1_addr));
        raw2  = bus.id_src2_used & pending_q[bus.id_src2_addr]
                & !(wb_valid_q && (wb_dest_q == bus.id_src2_addr));
        raw   = raw1 | raw2;
        waw   = bus.id_has_dest & pending_q[bus.id_dest_addr]
                & !(wb_valid_q && (wb_dest_q == bus.id_dest_addr));
        wbcol = 1'b0;
        for (int k = 1; k <= NSLOT; k++) begin
            if (bus.id_has_dest && (lat == LAT_W'(k)) && slot_v_q[k]) wbcol = 1'b1;
        end
        cbusy  = (bus.id_func_select == COMPLEX_FU_SEL) && (busy_q != '0);
        hazard = raw | waw | wbcol | cbusy;
        fire   = bus.id_valid & !hazard & !bus.ex_stall_in & !bus.flush;
    end

    assign bus.issue_fire   = fire;
    assign bus.id_stall     = bus.id_valid & !bus.flush & (hazard | bus.ex_stall_in);
    assign bus.idex_stall   = bus.ex_stall_in;
    assign bus.idex_clr     = !bus.ex_stall_in & (bus.flush | !fire);
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_dest_addr = wb_dest_q;

    always_comb begin
        slot_v_d = '0;
        for (int k = 1; k <= NSLOT; k++) slot_dst_d[k] = '0;
        for (int k = 1; k < NSLOT; k++) begin
            slot_v_d[k]   = slot_v_q[k+1];
            slot_dst_d[k] = slot_dst_q[k+1];
        end
        wb_valid_d = slot_v_q[1];
        wb_dest_d  = slot_dst_q[1];
        if (fire && bus.id_has_dest) begin
            if (lat == LAT_W'(1)) begin
                wb_valid_d = 1'b1;
                wb_dest_d  = bus.id_dest_addr;
            end
            for (int k = 1; k <= NSLOT; k++) begin
                if (lat == LAT_W'(k + 1)) begin
                    slot_v_d[k]   = 1'b1;
                    slot_dst_d[k] = bus.id_dest_addr;
                end
            end
        end

        // Clear first so a same-edge re-issue of the register keeps it pending.
        pending_d = pending_q;
        if (wb_valid_q) pending_d[wb_dest_q] = 1'b0;
        if (fire && bus.id_has_dest) pending_d[bus.id_dest_addr] = 1'b1;

        busy_d = busy_q;
        if (fire && (bus.id_func_select == COMPLEX_FU_SEL)) busy_d = lat - LAT_W'(1);
        else if (busy_q != '0)                              busy_d = busy_q - LAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            slot_v_q   <= '0;
            for (int k = 1; k <= NSLOT; k++) slot_dst_q[k] <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
            busy_q     <= '0;
        end else begin
            pending_q  <= pending_d;
            slot_v_q   <= slot_v_d;
            for (int k = 1; k <= NSLOT; k++) slot_dst_q[k] <= slot_dst_d[k];
            wb_valid_q <= wb_valid_d;
            wb_dest_q  <= wb_dest_d;
            busy_q     <= busy_d;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_raw_q, perf_raw_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_raw_d   = perf_raw_q;
        if (bus.id_stall && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
        if (bus.id_stall && raw && (perf_raw_q != 32'hFFFF_FFFF)) perf_raw_d = perf_raw_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_raw_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_raw_q   <= perf_raw_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_raw_stalls   = perf_raw_q;
`endif
endmodule

// File: tb/tb_ex_issue_scheduler.sv
// Directed bench for ex_issue_scheduler: per-cycle control checks plus a writeback scoreboard
// keyed on {due cycle, destination}.
module tb_ex_issue_scheduler;
    localparam int ADDR_W = 6;
    localparam int LAT_W  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_issue_if #(.ADDR_W(ADDR_W), .LAT_W(LAT_W)) bus ();
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_raw_stalls;
`endif

    ex_issue_scheduler #(.ADDR_W(ADDR_W), .LAT_W(LAT_W), .COMPLEX_FU_SEL(3'd2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_raw_stalls   (perf_raw_stalls)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [37:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] fs, input logic [3:0] lat,
                         input logic hd, input logic [5:0] dst,
                         input logic u1, input logic [5:0] a1, input logic u2, input logic [5:0] a2,
                         input logic exs, input logic fl);
        bus.id_valid       = v;
        bus.id_func_select = fs;
        bus.id_latency     = lat;
        bus.id_has_dest    = hd;
        bus.id_dest_addr   = dst;
        bus.id_src1_used   = u1;
        bus.id_src1_addr   = a1;
        bus.id_src2_used   = u2;
        bus.id_src2_addr   = a2;
        bus.ex_stall_in    = exs;
        bus.flush          = fl;
    endtask

    // One cycle: drive, check combinational controls mid-cycle, log the expected writeback.
    task automatic op(input logic v, input logic [2:0] fs, input logic [3:0] lat,
                      input logic hd, input logic [5:0] dst,
                      input logic u1, input logic [5:0] a1, input logic u2, input logic [5:0] a2,
                      input logic exs, input logic fl,
                      input logic e_fire, input logic e_stall, input logic e_clr);
        int leff;
        drive(v, fs, lat, hd, dst, u1, a1, u2, a2, exs, fl);
        @(negedge clk);
        chk("issue_fire", 32'(bus.issue_fire), 32'(e_fire));
        chk("id_stall",   32'(bus.id_stall),   32'(e_stall));
        chk("idex_clr",   32'(bus.idex_clr),   32'(e_clr));
        chk("idex_stall", 32'(bus.idex_stall), 32'(exs));
        leff = (lat == 4'd0) ? 1 : int'(lat);
        if (e_fire && hd) exp_q.push_back({32'(cyc + leff), dst});
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        op(0, 3'd0, 4'd0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nop();
    endtask

    task automatic do_reset(input int n);
        exp_q.delete();
        reset = 1'b1;
        drive(0, 3'd0, 4'd0, 0, 6'd0, 0, 6'd0, 0, 6'd0, 0, 0);
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Writeback monitor: every non-reset cycle, wb_valid must match whether an entry is due.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            int idx;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i][37:6] == 32'(cyc)) idx = i;
            end
            chk("wb_valid", 32'(bus.wb_valid), (idx >= 0) ? 32'd1 : 32'd0);
            if (idx >= 0) begin
                if (bus.wb_valid === 1'b1)
                    chk("wb_dest_addr", 32'(bus.wb_dest_addr), 32'(exp_q[idx][5:0]));
                exp_q.delete(idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(2);
        chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("reset_wb_dest",  32'(bus.wb_dest_addr), 32'd0);
        idle(1);

        // L=3 dest 5; dependent reader stalls until the wb cycle bypass
        op(1, 3'd0, 4'd3, 1, 6'd5, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd0, 4'd1, 0, 6'd0, 1, 6'd5, 0, 6'd0, 0, 0, 0, 1, 1);
        op(1, 3'd0, 4'd1, 0, 6'd0, 1, 6'd5, 0, 6'd0, 0, 0, 0, 1, 1);
        op(1, 3'd0, 4'd1, 0, 6'd0, 1, 6'd5, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(2);

        // L=4 dest 7; src1=7 reader issues at c4
        op(1, 3'd0, 4'd4, 1, 6'd7, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) op(1, 3'd0, 4'd1, 1, 6'd8, 1, 6'd7, 0, 6'd0, 0, 0, 0, 1, 1);
        op(1, 3'd0, 4'd1, 1, 6'd8, 1, 6'd7, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(2);

        // src2 RAW
        op(1, 3'd0, 4'd2, 1, 6'd9, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd0, 4'd1, 0, 6'd0, 0, 6'd0, 1, 6'd9, 0, 0, 0, 1, 1);
        op(1, 3'd0, 4'd1, 0, 6'd0, 0, 6'd0, 1, 6'd9, 0, 0, 1, 0, 0);
        idle(2);

        // writeback-port collision
        op(1, 3'd0, 4'd3, 1, 6'd1, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd0, 4'd2, 1, 6'd2, 0, 6'd0, 0, 6'd0, 0, 0, 0, 1, 1);
        op(1, 3'd0, 4'd2, 1, 6'd2, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(3);

        // complex ALU busy, L=5
        op(1, 3'd2, 4'd5, 1, 6'd10, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) op(1, 3'd2, 4'd5, 1, 6'd11, 0, 6'd0, 0, 6'd0, 0, 0, 0, 1, 1);
        op(1, 3'd2, 4'd5, 1, 6'd11, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(6);

        // latency 0 treated as 1; back-to-back complex ops at L=1
        op(1, 3'd2, 4'd0, 1, 6'd12, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd2, 4'd1, 1, 6'd13, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(2);

        // WAW: same dest re-issues in the wb cycle
        op(1, 3'd0, 4'd5, 1, 6'd50, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) op(1, 3'd0, 4'd1, 1, 6'd50, 0, 6'd0, 0, 6'd0, 0, 0, 0, 1, 1);
        op(1, 3'd0, 4'd1, 1, 6'd50, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(2);

        // downstream backpressure with an op in flight
        op(1, 3'd0, 4'd3, 1, 6'd20, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd0, 4'd1, 1, 6'd21, 0, 6'd0, 0, 6'd0, 1, 0, 0, 1, 0);
        op(1, 3'd0, 4'd1, 1, 6'd21, 0, 6'd0, 0, 6'd0, 1, 0, 0, 1, 0);
        op(1, 3'd0, 4'd1, 1, 6'd21, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        idle(2);

        // flush of a hazarding instruction while an op is in flight
        op(1, 3'd0, 4'd3, 1, 6'd30, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd0, 4'd1, 1, 6'd31, 1, 6'd30, 0, 6'd0, 0, 1, 0, 0, 1);
        idle(3);

        // reset with three ops in flight discards them
        op(1, 3'd0, 4'd5, 1, 6'd40, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd0, 4'd6, 1, 6'd41, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        op(1, 3'd2, 4'd7, 1, 6'd42, 0, 6'd0, 0, 6'd0, 0, 0, 1, 0, 0);
        do_reset(1);
        op(1, 3'd2, 4'd1, 1, 6'd42, 1, 6'd40, 1, 6'd41, 0, 0, 1, 0, 0);
        idle(9);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
